// File: rtl/stall_ctrl_if.sv
// Hazard-unit bundle: decode/execute/memory operand info in, stall controls
// and mult/div busy view out.
interface stall_ctrl_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_Tuse_rs;
    logic [1:0]  D_Tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_A3;
    logic [1:0]  E_Tnew;
    logic [4:0]  M_A3;
    logic [1:0]  M_Tnew;
    logic        E_md_start;
    logic        E_md_div;
    logic        stall;
    logic        PC_en;
    logic        D_en;
    logic        E_clear;
    logic        md_busy;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        output E_A3, E_Tnew, M_A3, M_Tnew, E_md_start, E_md_div,
        input  stall, PC_en, D_en, E_clear, md_busy, md_cnt, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        input  E_A3, E_Tnew, M_A3, M_Tnew, E_md_start, E_md_div,
        output stall, PC_en, D_en, E_clear, md_busy, md_cnt, stall_cnt
    );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: Tuse/Tnew data-hazard detection, mult/div busy
// countdown, and a free-running count of stalled cycles.
module stall_ctrl (
    input  logic         clk,
    input  logic         reset,
    stall_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t   w_state;
    logic [3:0]  r_md_cnt;
    logic [3:0]  w_md_cnt_next;
    logic [31:0] r_stall_cnt;
    logic        w_hz_rs;
    logic        w_hz_rt;
    logic        w_hz_md;
    logic        w_md_busy;
    logic        w_stall;

    // A nonzero source can never equal a zero destination, so the src!=0 test
    // also masks "no destination" producers.
    function automatic logic hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((src == e_a3) && (e_tnew > tuse)) ||
                ((src == m_a3) && (m_tnew > tuse)));
    endfunction

    always_comb begin
        w_hz_rs   = hazard(bus.D_rs, bus.D_Tuse_rs, bus.E_A3, bus.E_Tnew,
                           bus.M_A3, bus.M_Tnew);
        w_hz_rt   = hazard(bus.D_rt, bus.D_Tuse_rt, bus.E_A3, bus.E_Tnew,
                           bus.M_A3, bus.M_Tnew);
        w_md_busy = bus.E_md_start | (r_md_cnt != 4'd0);
        w_hz_md   = bus.D_is_md & w_md_busy;
        w_stall   = w_hz_rs | w_hz_rt | w_hz_md;
    end

    // The FSM state is a view of the counter; no separate state register.
    always_comb begin
        w_state       = (r_md_cnt == 4'd0) ? IDLE : BUSY;
        w_md_cnt_next = r_md_cnt;
        case (w_state)
            IDLE: if (bus.E_md_start) w_md_cnt_next = bus.E_md_div ? 4'd10 : 4'd5;
            BUSY: w_md_cnt_next = r_md_cnt - 4'd1;
            default: w_md_cnt_next = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt    <= 4'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_md_cnt <= w_md_cnt_next;
            if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.PC_en     = ~w_stall;
    assign bus.D_en      = ~w_stall;
    assign bus.E_clear   = w_stall;
    assign bus.md_busy   = w_md_busy;
    assign bus.md_cnt    = r_md_cnt;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops and compares them mid-cycle.
module tb_stall_ctrl;
    logic clk;
    logic reset;
    stall_ctrl_if bus ();

    stall_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        logic [3:0]  cnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    // Advance one cycle and return all inputs to the quiet (no-hazard) pattern.
    task automatic cyc();
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.D_rs       = 5'd0;
        bus.D_rt       = 5'd0;
        bus.D_Tuse_rs  = 2'd3;
        bus.D_Tuse_rt  = 2'd3;
        bus.D_is_md    = 1'b0;
        bus.E_A3       = 5'd0;
        bus.E_Tnew     = 2'd0;
        bus.M_A3       = 5'd0;
        bus.M_Tnew     = 2'd0;
        bus.E_md_start = 1'b0;
        bus.E_md_div   = 1'b0;
    endtask

    task automatic expect_v(input string name, input logic st, input logic busy,
                            input logic [3:0] cnt, input logic [31:0] scnt);
        exp_t e;
        e.name = name; e.stall = st; e.busy = busy; e.cnt = cnt; e.scnt = scnt;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                $display("txn %-10s stall=%0b pc_en=%0b d_en=%0b e_clr=%0b busy=%0b cnt=%0d scnt=%0h",
                         e.name, bus.stall, bus.PC_en, bus.D_en, bus.E_clear,
                         bus.md_busy, bus.md_cnt, bus.stall_cnt);
                if (bus.stall !== e.stall || bus.PC_en !== ~e.stall ||
                    bus.D_en !== ~e.stall || bus.E_clear !== e.stall ||
                    bus.md_busy !== e.busy || bus.md_cnt !== e.cnt ||
                    bus.stall_cnt !== e.scnt) begin
                    errors++;
                    $display("FAIL %s: got stall=%0b pc_en=%0b d_en=%0b e_clr=%0b busy=%0b cnt=%0d scnt=%0h want stall=%0b pc_en=%0b d_en=%0b e_clr=%0b busy=%0b cnt=%0d scnt=%0h",
                             e.name, bus.stall, bus.PC_en, bus.D_en, bus.E_clear,
                             bus.md_busy, bus.md_cnt, bus.stall_cnt,
                             e.stall, ~e.stall, ~e.stall, e.stall, e.busy, e.cnt, e.scnt);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b1;
        expect_v("reset", 0, 0, 0, 0);
        cyc();
        expect_v("idle", 0, 0, 0, 0);

        // Load-use through E then M
        cyc(); bus.D_rs = 5'd8; bus.D_Tuse_rs = 2'd0; bus.E_A3 = 5'd8; bus.E_Tnew = 2'd2;
        expect_v("lu_e", 1, 0, 0, 0);
        cyc(); bus.D_rs = 5'd8; bus.D_Tuse_rs = 2'd0; bus.M_A3 = 5'd8; bus.M_Tnew = 2'd1;
        expect_v("lu_m", 1, 0, 0, 1);
        cyc(); bus.D_rs = 5'd8; bus.D_Tuse_rs = 2'd0; bus.M_A3 = 5'd8; bus.M_Tnew = 2'd0;
        expect_v("lu_ok", 0, 0, 0, 2);

        // Register zero and non-hazard cases
        cyc(); bus.D_rs = 5'd0; bus.D_Tuse_rs = 2'd0; bus.E_A3 = 5'd0; bus.E_Tnew = 2'd2;
        expect_v("zero", 0, 0, 0, 2);
        cyc(); bus.D_rt = 5'd9; bus.D_Tuse_rt = 2'd1; bus.E_A3 = 5'd9; bus.E_Tnew = 2'd1;
        expect_v("rt_ok", 0, 0, 0, 2);
        cyc(); bus.D_rt = 5'd9; bus.D_Tuse_rt = 2'd0; bus.E_A3 = 5'd9; bus.E_Tnew = 2'd1;
        expect_v("rt_hz", 1, 0, 0, 2);
        cyc(); bus.D_rt = 5'd9; bus.D_Tuse_rt = 2'd1; bus.M_A3 = 5'd9; bus.M_Tnew = 2'd2;
        expect_v("rt_m", 1, 0, 0, 3);
        cyc(); bus.D_rs = 5'd8; bus.D_rt = 5'd9; bus.E_A3 = 5'd8; bus.E_Tnew = 2'd3;
        bus.M_A3 = 5'd9; bus.M_Tnew = 2'd3;
        expect_v("tuse3", 0, 0, 0, 4);

        // Mult with a dependent md instruction in D
        cyc(); bus.D_is_md = 1'b1; bus.E_md_start = 1'b1;
        expect_v("mul_st", 1, 1, 0, 4);
        for (int i = 0; i < 5; i++) begin
            cyc(); bus.D_is_md = 1'b1;
            expect_v("mul_run", 1, 1, 4'(5 - i), 32'(5 + i));
        end
        cyc(); bus.D_is_md = 1'b1;
        expect_v("mul_done", 0, 0, 0, 10);

        // Div; restarts at cnt=3 and cnt=1 are ignored
        cyc(); bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        expect_v("div_st", 0, 1, 0, 10);
        for (int i = 0; i < 7; i++) begin
            cyc();
            expect_v("div_run", 0, 1, 4'(10 - i), 10);
        end
        cyc(); bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        expect_v("div_rst3", 0, 1, 3, 10);
        cyc();
        expect_v("div_run", 0, 1, 2, 10);
        cyc(); bus.E_md_start = 1'b1;
        expect_v("div_rst1", 0, 1, 1, 10);
        cyc();
        expect_v("div_done", 0, 0, 0, 10);

        // Reset in the middle of a div
        cyc(); bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        expect_v("div2_st", 0, 1, 0, 10);
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_v("div2_run", 0, 1, 4'(10 - i), 10);
        end
        cyc(); reset = 1'b1;
        expect_v("rst_mid", 0, 1, 6, 10);
        cyc();
        expect_v("post_rst", 0, 0, 0, 0);

        // Reset beats start and suppresses counting; outputs stay combinational
        cyc(); reset = 1'b1; bus.E_md_start = 1'b1; bus.D_is_md = 1'b1;
        expect_v("rst_start", 1, 1, 0, 0);
        cyc();
        expect_v("rst_start2", 0, 0, 0, 0);

        // Wrap of the stall counter
        cyc(); bus.D_rs = 5'd8; bus.D_Tuse_rs = 2'd0; bus.E_A3 = 5'd8; bus.E_Tnew = 2'd2;
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        expect_v("wrap_pre", 1, 0, 0, 32'hFFFF_FFFF);
        cyc();
        expect_v("wrap", 0, 0, 0, 0);

        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 2000) begin
            errors++;
            $display("FAIL timeout: got %0d pending entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 The block SHALL use one clock, clk, with synchronous active-high reset, reset, sampled on the rising edge of clk.
REQ-002 The ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- D_rs  in  5  D-stage rs register number
- D_rt  in  5  D-stage rt register number
- D_Tuse_rs  in  2  cycles until D instruction needs rs (3 = never)
- D_Tuse_rt  in  2  cycles until D instruction needs rt (3 = never)
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_A3  in  5  E-stage destination register (0 = none)
- E_Tnew  in  2  cycles until E result is ready
- M_A3  in  5  M-stage destination register (0 = none)
- M_Tnew  in  2  cycles until M result is ready
- E_md_start  in  1  E-stage instruction is mult/multu/div/divu
- E_md_div  in  1  with E_md_start: 1 = div/divu, 0 = mult/multu
- stall  out  1  pipeline stall this cycle
- PC_en  out  1  PC write enable
- D_en  out  1  D-register write enable
- E_clear  out  1  bubble into E register (drives its blockSign)
- md_busy  out  1  mult/div unit busy (combinational view)
- md_cnt  out  4  remaining busy cycles
- stall_cnt  out  32  total stalled cycles since reset

Function
REQ-003 The block SHALL assert hz_rs when D_rs!=0 and either (D_rs==E_A3 and E_Tnew>D_Tuse_rs) or (D_rs==M_A3 and M_Tnew>D_Tuse_rs).
REQ-004 The block SHALL assert hz_rt by the same rule, using D_rt and D_Tuse_rt.
REQ-005 Register 0 SHALL never cause a hazard, and an E_A3 or M_A3 of 0 SHALL never match.
REQ-006 The block SHALL assert hz_md = D_is_md & md_busy.
REQ-007 The block SHALL assert md_busy = E_md_start | (md_cnt!=0), combinationally.
REQ-008 The block SHALL compute stall = hz_rs | hz_rt | hz_md, combinationally in the same cycle.
REQ-009 The block SHALL drive PC_en = D_en = ~stall and E_clear = stall.
REQ-010 The mult/div FSM SHALL have two states, IDLE (md_cnt==0) and BUSY (md_cnt!=0).
REQ-011 In IDLE with E_md_start=1 at a clock edge, the block SHALL load md_cnt with 10 when E_md_div=1, else 5.
REQ-012 In BUSY, md_cnt SHALL decrement by 1 per clock and return to IDLE on reaching 0, so md_busy stays high for exactly N+1 cycles counting the start cycle.
REQ-013 The block SHALL ignore E_md_start in BUSY, with md_cnt unaffected.
REQ-014 E_md_start in the same cycle md_cnt goes from 1 to 0 SHALL be ignored, since the FSM is still BUSY.
REQ-015 The block SHALL increment stall_cnt by 1 on each clock edge where stall=1 and reset=0.
REQ-016 stall_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-017 With all Tuse=3 and all Tnew=0, the block SHALL never stall.

Reset
REQ-018 On reset at a clock edge, the block SHALL set md_cnt=0 and stall_cnt=0, making md_busy=E_md_start.
REQ-019 Reset SHALL take priority over E_md_start and over a counter decrement.
REQ-020 Reset mid-operation SHALL abort any mult/div count immediately.
REQ-021 Combinational outputs SHALL follow their inputs during reset.
REQ-022 After reset with inputs 0, outputs SHALL be: stall=0, PC_en=1, D_en=1, E_clear=0, md_busy=0, md_cnt=0, stall_cnt=0.
REQ-023 The block SHALL hold no state beyond md_cnt and stall_cnt.

Verification
REQ-024 Load-use: D_rs=8, D_Tuse_rs=0, E_A3=8, E_Tnew=2 -> stall=1, PC_en=0, E_clear=1. Then M_A3=8, M_Tnew=1 -> stall=1. Then M_Tnew=0 -> stall=0. stall_cnt=2.
REQ-025 Zero/no-hazard: D_rs=0, E_A3=0, E_Tnew=2 -> stall=0. D_rt=9, D_Tuse_rt=1, E_A3=9, E_Tnew=1 -> stall=0.
REQ-026 Mult: E_md_start=1, E_md_div=0 for one cycle -> md_cnt reads 5,4,3,2,1,0 on the following edges. D_is_md=1 throughout -> stall=1 for 6 cycles (start cycle + 5), then 0.
REQ-027 Div with ignored restart: div start, then E_md_start=1 again when md_cnt=3 -> md_cnt continues 2,1,0; total busy 11 cycles.
REQ-028 Reset mid-div: reset at md_cnt=6 -> next cycle md_cnt=0, md_busy=0, stall_cnt=0.
REQ-029 Wrap: preload stall_cnt to 0xFFFFFFFF (force), one stalled cycle -> stall_cnt=0.
